// File: rtl/v_pkg.sv
// Shared types and constants for the sequential vector load/store unit.
package v_pkg;

    localparam logic [1:0] EW_8  = 2'b00;
    localparam logic [1:0] EW_16 = 2'b01;
    localparam logic [1:0] EW_32 = 2'b10;

    // Element counts are held at this width regardless of the VLW parameter.
    localparam int VL_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        FIN    = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic            store;
        logic            strided;
        logic [1:0]      ew;
        logic [31:0]     base;
        logic [31:0]     stride;
        logic [VL_W-1:0] vl;
    } vlsu_op_t;

endpackage

// File: rtl/vlsu_lane.sv
// Per-lane data steering: word address, byte enables, store alignment,
// load extraction and misalignment detection for one element.
module vlsu_lane
    import v_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  ew,
    input  logic        is_store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] word_addr,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ex,
    output logic        misalign
);

    logic [1:0]  off;
    logic [31:0] shifted;

    assign off       = addr[1:0];
    assign word_addr = {addr[31:2], 2'b00};
    assign wdata_al  = wdata << {off, 3'b000};
    assign shifted   = rdata >> {off, 3'b000};

    always_comb begin
        be       = 4'hF;
        rdata_ex = shifted;
        misalign = 1'b0;
        case (ew)
            EW_8: begin
                if (is_store) be = 4'b0001 << off;
                rdata_ex = {24'b0, shifted[7:0]};
            end
            EW_16: begin
                if (is_store) be = 4'b0011 << off;
                rdata_ex = {16'b0, shifted[15:0]};
                misalign = off[0];
            end
            default: begin
                misalign = (off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/vlsu_seq.sv
// Sequential vector LSU: walks op_vl elements in beats of NLANES, one
// memory word port per lane, and writes packed load beats back to the VRF.
module vlsu_seq
    import v_pkg::*;
#(
    parameter int NLANES = 4,
    parameter int MAX_VL = 32,
    parameter int VLW    = 6,
    parameter int BW     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic                 op_store,
    input  logic                 op_strided,
    input  logic [1:0]           op_ew,
    input  logic [31:0]          op_base,
    input  logic [31:0]          op_stride,
    input  logic [VLW-1:0]       op_vl,
    input  logic [NLANES*32-1:0] st_data,
    output logic [BW-1:0]        beat_idx,
    output logic [NLANES-1:0]    mem_req,
    output logic [NLANES*32-1:0] mem_addr,
    output logic                 mem_we,
    output logic [NLANES*4-1:0]  mem_be,
    output logic [NLANES*32-1:0] mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [NLANES*32-1:0] mem_rdata,
    output logic                 ld_valid,
    output logic [NLANES*32-1:0] ld_data,
    output logic [NLANES-1:0]    ld_mask,
    output logic                 done,
    output logic                 err,
    output lsu_state_t           dbg_state
);

    // Handshakes: an op transfers on a cycle with op_valid && op_ready; a
    // memory beat transfers on mem_gnt while requests are held stable, and
    // read data is taken on the first mem_rvalid seen in WAIT_R.

    lsu_state_t      state_q, state_d;
    vlsu_op_t        op_q, op_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [VL_W-1:0] elem_q, elem_d;
    logic [31:0]     bbase_q, bbase_d;
    logic            err_q, err_d;

    logic [31:0]       lane_addr  [NLANES];
    logic [31:0]       lane_waddr [NLANES];
    logic [3:0]        lane_be    [NLANES];
    logic [31:0]       lane_wd    [NLANES];
    logic [31:0]       lane_rd    [NLANES];
    logic [NLANES-1:0] lane_mis;
    logic [NLANES-1:0] active;
    logic              any_mis;
    logic              last_beat;
    logic              advance;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        assign lane_addr[i] = bbase_q + op_q.stride * 32'(i);
        assign active[i]    = (elem_q + VL_W'(i)) < op_q.vl;

        vlsu_lane u_lane (
            .addr      (lane_addr[i]),
            .ew        (op_q.ew),
            .is_store  (op_q.store),
            .wdata     (st_data[32*i +: 32]),
            .rdata     (mem_rdata[32*i +: 32]),
            .word_addr (lane_waddr[i]),
            .be        (lane_be[i]),
            .wdata_al  (lane_wd[i]),
            .rdata_ex  (lane_rd[i]),
            .misalign  (lane_mis[i])
        );
    end

    assign any_mis   = |(lane_mis & active);
    assign last_beat = (elem_q + VL_W'(NLANES)) >= op_q.vl;
    assign beat_idx  = beat_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        beat_d    = beat_q;
        elem_d    = elem_q;
        bbase_d   = bbase_q;
        err_d     = err_q;
        advance   = 1'b0;
        op_ready  = 1'b0;
        mem_req   = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_mask   = '0;
        done      = 1'b0;
        err       = 1'b0;

        case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    op_d.store   = op_store;
                    op_d.strided = op_strided;
                    op_d.ew      = op_ew;
                    op_d.base    = op_base;
                    // Unit stride is the element size in bytes.
                    op_d.stride  = op_strided ? op_stride : (32'd1 << op_ew);
                    op_d.vl      = (op_vl > VLW'(MAX_VL)) ? VL_W'(MAX_VL) : VL_W'(op_vl);
                    beat_d       = '0;
                    elem_d       = '0;
                    bbase_d      = op_base;
                    err_d        = (op_ew == 2'b11);
                    state_d      = (op_ew == 2'b11 || op_vl == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (any_mis) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    mem_req = active;
                    mem_we  = op_q.store;
                    for (int i = 0; i < NLANES; i++) begin
                        if (active[i]) begin
                            mem_addr[32*i +: 32] = lane_waddr[i];
                            mem_be[4*i +: 4]     = lane_be[i];
                            if (op_q.store) mem_wdata[32*i +: 32] = lane_wd[i];
                        end
                    end
                    if (mem_gnt) begin
                        if (op_q.store) begin
                            advance = 1'b1;
                            state_d = last_beat ? FIN : ISSUE;
                        end else begin
                            state_d = WAIT_R;
                        end
                    end
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    ld_valid = 1'b1;
                    ld_mask  = active;
                    for (int i = 0; i < NLANES; i++) begin
                        if (active[i]) ld_data[32*i +: 32] = lane_rd[i];
                    end
                    advance = 1'b1;
                    state_d = last_beat ? FIN : ISSUE;
                end
            end
            default: begin
                done    = 1'b1;
                err     = err_q;
                err_d   = 1'b0;
                beat_d  = '0;
                elem_d  = '0;
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            beat_d  = beat_q + 1'b1;
            elem_d  = elem_q + VL_W'(NLANES);
            bbase_d = bbase_q + op_q.stride * 32'(NLANES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            beat_q  <= '0;
            elem_q  <= '0;
            bbase_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            beat_q  <= beat_d;
            elem_q  <= elem_d;
            bbase_q <= bbase_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_vlsu_seq.sv
// Directed bench for vlsu_seq: a table of single-beat ops plus hand-written
// multi-beat, stall, fault and reset sequences.
module tb_vlsu_seq;
    import v_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic         op_store = 1'b0;
    logic         op_strided = 1'b0;
    logic [1:0]   op_ew = 2'b00;
    logic [31:0]  op_base = '0;
    logic [31:0]  op_stride = '0;
    logic [5:0]   op_vl = '0;
    logic [127:0] st_data = '0;
    logic [2:0]   beat_idx;
    logic [3:0]   mem_req;
    logic [127:0] mem_addr;
    logic         mem_we;
    logic [15:0]  mem_be;
    logic [127:0] mem_wdata;
    logic         mem_gnt = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic         ld_valid;
    logic [127:0] ld_data;
    logic [3:0]   ld_mask;
    logic         done;
    logic         err;
    lsu_state_t   dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] RD  = {32'hDEADBEEF, 32'h55667788, 32'hAABBCCDD, 32'h11223344};
    localparam logic [127:0] RD2 = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};

    vlsu_seq #(.NLANES(4), .MAX_VL(32), .VLW(6), .BW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_store   (op_store),
        .op_strided (op_strided),
        .op_ew      (op_ew),
        .op_base    (op_base),
        .op_stride  (op_stride),
        .op_vl      (op_vl),
        .st_data    (st_data),
        .beat_idx   (beat_idx),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_mask    (ld_mask),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         store;
        logic         strided;
        logic [1:0]   ew;
        logic [31:0]  base;
        logic [31:0]  stride;
        logic [5:0]   vl;
        logic [127:0] st;
        logic         exp_err;
        logic [3:0]   req;
        logic [127:0] addr;
        logic [15:0]  be;
        logic [127:0] wd;
        logic [127:0] ld;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue_op(input logic st, input logic sd, input logic [1:0] ew,
                            input logic [31:0] base, input logic [31:0] stride,
                            input logic [5:0] vl);
        int n;
        n = 0;
        while (!op_ready && n < 20) begin
            tick();
            n++;
        end
        chk("op_ready_wait", 128'(op_ready), 128'(1));
        op_store = st; op_strided = sd; op_ew = ew;
        op_base = base; op_stride = stride; op_vl = vl;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic seen_req, got_done, got_err;
        issue_op(v.store, v.strided, v.ew, v.base, v.stride, v.vl);
        st_data = v.st;
        mem_rdata = RD;
        #1;
        if (v.exp_err) begin
            seen_req = 1'b0; got_done = 1'b0; got_err = 1'b0;
            for (int n = 0; n < 4 && !got_done; n++) begin
                if (mem_req != 4'b0) seen_req = 1'b1;
                if (done) begin
                    got_done = 1'b1;
                    got_err  = err;
                end else begin
                    tick();
                end
            end
            chk($sformatf("v%0d_fault_req", idx), 128'(seen_req), 128'(0));
            chk($sformatf("v%0d_fault_done", idx), 128'(got_done), 128'(1));
            chk($sformatf("v%0d_fault_err", idx), 128'(got_err), 128'(1));
        end else begin
            chk($sformatf("v%0d_req", idx), 128'(mem_req), 128'(v.req));
            chk($sformatf("v%0d_addr", idx), mem_addr, v.addr);
            chk($sformatf("v%0d_be", idx), 128'(mem_be), 128'(v.be));
            chk($sformatf("v%0d_wdata", idx), mem_wdata, v.wd);
            chk($sformatf("v%0d_we", idx), 128'(mem_we), 128'(v.store));
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
            if (!v.store) begin
                #1;
                chk($sformatf("v%0d_wait_req", idx), 128'(mem_req), 128'(0));
                mem_rvalid = 1'b1;
                #1;
                chk($sformatf("v%0d_ld_valid", idx), 128'(ld_valid), 128'(1));
                chk($sformatf("v%0d_ld_data", idx), ld_data, v.ld);
                chk($sformatf("v%0d_ld_mask", idx), 128'(ld_mask), 128'(v.req));
                tick();
                mem_rvalid = 1'b0;
            end
            #1;
            chk($sformatf("v%0d_done", idx), 128'(done), 128'(1));
            chk($sformatf("v%0d_err", idx), 128'(err), 128'(0));
        end
        tick();
        chk($sformatf("v%0d_ready_after", idx), 128'(op_ready), 128'(1));
    endtask

    initial begin
        logic seen;

        vecs[0] = '{1'b0, 1'b0, EW_16, 32'h2000, 32'h0, 6'd3, 128'h0, 1'b0, 4'b0111,
                    {32'h0, 32'h2004, 32'h2000, 32'h2000}, 16'h0FFF, 128'h0,
                    {32'h0, 32'h7788, 32'hAABB, 32'h3344}};
        vecs[1] = '{1'b1, 1'b1, EW_8, 32'h10, 32'h5, 6'd4,
                    {32'hD4, 32'hC3, 32'hB2, 32'hA1}, 1'b0, 4'b1111,
                    {32'h1C, 32'h18, 32'h14, 32'h10}, 16'h8421,
                    {32'hD4000000, 32'h00C30000, 32'h0000B200, 32'h000000A1}, 128'h0};
        vecs[2] = '{1'b0, 1'b1, EW_32, 32'h400, 32'h100, 6'd2, 128'h0, 1'b0, 4'b0011,
                    {32'h0, 32'h0, 32'h500, 32'h400}, 16'h00FF, 128'h0,
                    {32'h0, 32'h0, 32'hAABBCCDD, 32'h11223344}};
        vecs[3] = '{1'b1, 1'b0, EW_32, 32'hFFFFFFFC, 32'h0, 6'd2,
                    {32'h0, 32'h0, 32'h05060708, 32'h01020304}, 1'b0, 4'b0011,
                    {32'h0, 32'h0, 32'h00000000, 32'hFFFFFFFC}, 16'h00FF,
                    {32'h0, 32'h0, 32'h05060708, 32'h01020304}, 128'h0};
        vecs[4] = '{1'b0, 1'b1, EW_8, 32'h3, 32'hFFFFFFFF, 6'd4, 128'h0, 1'b0, 4'b1111,
                    128'h0, 16'hFFFF, 128'h0,
                    {32'hEF, 32'h77, 32'hBB, 32'h11}};
        vecs[5] = '{1'b0, 1'b1, EW_16, 32'h0, 32'h1, 6'd1, 128'h0, 1'b0, 4'b0001,
                    128'h0, 16'h000F, 128'h0, {96'h0, 32'h3344}};
        vecs[6] = '{1'b0, 1'b0, EW_32, 32'h1002, 32'h0, 6'd4, 128'h0, 1'b1, 4'b0,
                    128'h0, 16'h0, 128'h0, 128'h0};
        vecs[7] = '{1'b1, 1'b0, EW_16, 32'h31, 32'h0, 6'd1, 128'h0, 1'b1, 4'b0,
                    128'h0, 16'h0, 128'h0, 128'h0};
        vecs[8] = '{1'b0, 1'b0, 2'b11, 32'h0, 32'h0, 6'd3, 128'h0, 1'b1, 4'b0,
                    128'h0, 16'h0, 128'h0, 128'h0};
        vecs[9] = '{1'b0, 1'b1, EW_32, 32'h0, 32'h2, 6'd2, 128'h0, 1'b1, 4'b0,
                    128'h0, 16'h0, 128'h0, 128'h0};

        // Reset state.
        tick();
        tick();
        chk("rst_ready", 128'(op_ready), 128'(1));
        chk("rst_req", 128'(mem_req), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_beat", 128'(beat_idx), 128'(0));
        chk("rst_state", 128'(dbg_state), 128'(IDLE));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Two-beat byte load with a stray rvalid while in ISSUE.
        issue_op(1'b0, 1'b0, EW_8, 32'h101, 32'h0, 6'd6);
        mem_rdata = RD;
        #1;
        chk("s1_b0_beat", 128'(beat_idx), 128'(0));
        chk("s1_b0_req", 128'(mem_req), 128'(4'hF));
        chk("s1_b0_addr", mem_addr, {32'h104, 32'h100, 32'h100, 32'h100});
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk("s1_b0_ld_valid", 128'(ld_valid), 128'(1));
        chk("s1_b0_ld_data", ld_data, {32'hEF, 32'h55, 32'hBB, 32'h33});
        chk("s1_b0_ld_mask", 128'(ld_mask), 128'(4'hF));
        tick();
        #1;
        chk("s1_stray_rvalid", 128'(ld_valid), 128'(0));
        chk("s1_b1_beat", 128'(beat_idx), 128'(1));
        chk("s1_b1_req", 128'(mem_req), 128'(4'b0011));
        chk("s1_b1_addr", mem_addr, {32'h0, 32'h0, 32'h104, 32'h104});
        mem_rvalid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk("s1_b1_ld_valid", 128'(ld_valid), 128'(1));
        chk("s1_b1_ld_data", ld_data, {32'h0, 32'h0, 32'hBB, 32'h33});
        chk("s1_b1_ld_mask", 128'(ld_mask), 128'(4'b0011));
        chk("s1_b1_ld_beat", 128'(beat_idx), 128'(1));
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("s1_done", 128'(done), 128'(1));
        chk("s1_err", 128'(err), 128'(0));
        tick();

        // Strided halfword store with negative stride.
        issue_op(1'b1, 1'b1, EW_16, 32'h202, 32'hFFFFFFFC, 6'd4);
        st_data = {32'hDEF0, 32'h9ABC, 32'h5678, 32'h1234};
        #1;
        chk("s2_addr", mem_addr, {32'h1F4, 32'h1F8, 32'h1FC, 32'h200});
        chk("s2_be", 128'(mem_be), 128'(16'hCCCC));
        chk("s2_wdata", mem_wdata, {32'hDEF00000, 32'h9ABC0000, 32'h56780000, 32'h12340000});
        chk("s2_we", 128'(mem_we), 128'(1));
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #1;
        chk("s2_done", 128'(done), 128'(1));
        tick();

        // Word load with grant withheld for three cycles.
        issue_op(1'b0, 1'b0, EW_32, 32'h1000, 32'h0, 6'd8);
        mem_rdata = RD;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("s3_hold%0d_req", k), 128'(mem_req), 128'(4'hF));
            chk($sformatf("s3_hold%0d_addr", k), mem_addr,
                {32'h100C, 32'h1008, 32'h1004, 32'h1000});
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #1;
        chk("s3_b0_no_early", 128'(ld_valid), 128'(0));
        tick();
        mem_rvalid = 1'b1;
        #1;
        chk("s3_b0_ld_data", ld_data, RD);
        chk("s3_b0_beat", 128'(beat_idx), 128'(0));
        tick();
        mem_rvalid = 1'b0;
        mem_rdata = RD2;
        #1;
        chk("s3_b1_beat", 128'(beat_idx), 128'(1));
        chk("s3_b1_addr", mem_addr, {32'h101C, 32'h1018, 32'h1014, 32'h1010});
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk("s3_b1_ld_data", ld_data, RD2);
        chk("s3_b1_ld_beat", 128'(beat_idx), 128'(1));
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("s3_done", 128'(done), 128'(1));
        tick();

        // Zero-length op.
        issue_op(1'b0, 1'b0, EW_8, 32'h0, 32'h0, 6'd0);
        #1;
        chk("s4_req", 128'(mem_req), 128'(0));
        chk("s4_done", 128'(done), 128'(1));
        chk("s4_err", 128'(err), 128'(0));
        tick();
        chk("s4_ready", 128'(op_ready), 128'(1));

        // Reset while waiting for read data.
        issue_op(1'b0, 1'b0, EW_32, 32'h40, 32'h0, 6'd4);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #1;
        chk("s5_in_wait", 128'(dbg_state), 128'(WAIT_R));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("s5_ready", 128'(op_ready), 128'(1));
        chk("s5_req", 128'(mem_req), 128'(0));
        mem_rvalid = 1'b1;
        #1;
        chk("s5_late_rvalid", 128'(ld_valid), 128'(0));
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done) seen = 1'b1;
        end
        mem_rvalid = 1'b0;
        chk("s5_no_done", 128'(seen), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
